// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input, frame clear and result output of the product accumulator
interface product_accumulator_if #(
  parameter int P     = 8,
  parameter int ACC_W = 10,
  parameter int CW    = 3
);
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [P-1:0]     prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  logic [CW-1:0]    count;
  modport master (
    output clr, in_valid, prod, out_ready,
    input  in_ready, out_valid, sum, ovf, count
  );
  modport slave (
    input  clr, in_valid, prod, out_ready,
    output in_ready, out_valid, sum, ovf, count
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums TERMS unsigned products per frame and holds the result until accepted
module product_accumulator #(
  parameter int m     = 4,
  parameter int n     = 4,
  parameter int TERMS = 4,
  parameter int ACC_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  product_accumulator_if.slave bus
);
  localparam int P  = m + n;
  localparam int CW = $clog2(TERMS) + 1;
  localparam logic [CW-1:0] LAST = CW'(TERMS - 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W:0]   w_add;
  // top bit of the widened add is the carry out of the accumulator
  always_comb w_add = {1'b0, r_acc} + {{(ACC_W + 1 - P){1'b0}}, bus.prod};
  always_ff @(posedge clk) begin
    if (!rst || bus.clr || (r_state == HOLD && bus.out_ready)) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (r_state == ACCUM && bus.in_valid && r_in_ready) begin
      r_acc   <= w_add[ACC_W-1:0];
      r_ovf   <= r_ovf | w_add[ACC_W];
      r_count <= r_count + 1'b1;
      if (r_count == LAST) begin
        r_state     <= HOLD;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b1;
      end
    end
  end
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_acc;
  assign bus.ovf       = r_ovf;
  assign bus.count     = r_count;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed and random frames against a frame-list reference model with a result scoreboard
module tb_product_accumulator;
  localparam int P = 8, TERMS = 4, ACC_W = 9, CW = 3;
  localparam int MOD = 2 ** ACC_W;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  product_accumulator_if #(.P(P), .ACC_W(ACC_W), .CW(CW)) bus();
  product_accumulator #(.m(4), .n(4), .TERMS(TERMS), .ACC_W(ACC_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_bad = 0;
  logic [ACC_W:0] exp_q[$];
  logic [ACC_W:0] e;
  int terms[$];
  bit m_hold = 0;

  function automatic int total();
    int t = 0;
    foreach (terms[i]) t += terms[i];
    return t;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && !bus.clr && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result_unexpected: got sum=%0d ovf=%0d, expected no result", bus.sum, bus.ovf);
      end else begin
        e = exp_q.pop_front();
        check("result_sum", int'(bus.sum), int'(e[ACC_W-1:0]));
        check("result_ovf", int'(bus.ovf), int'(e[ACC_W]));
        check("result_count", int'(bus.count), TERMS);
      end
    end
  end

  task automatic step(input bit rn, input bit c, input bit v, input int p, input bit o);
    int t;
    logic [ACC_W:0] x;
    rst = rn;
    bus.clr = c;
    bus.in_valid = v;
    bus.prod = P'(p);
    bus.out_ready = o;
    @(posedge clk);
    #1;
    if (!rn || c) begin
      if (m_hold) void'(exp_q.pop_back());
      m_hold = 0;
      terms.delete();
    end else if (m_hold) begin
      if (o) begin
        m_hold = 0;
        terms.delete();
      end
    end else if (v) begin
      terms.push_back(p);
      if (terms.size() == TERMS) begin
        t = total();
        x[ACC_W] = t >= MOD;
        x[ACC_W-1:0] = ACC_W'(t % MOD);
        exp_q.push_back(x);
        m_hold = 1;
      end
    end
    t = total();
    check("in_ready", int'(bus.in_ready), int'(!m_hold));
    check("out_valid", int'(bus.out_valid), int'(m_hold));
    check("count", int'(bus.count), m_hold ? TERMS : terms.size());
    check("sum", int'(bus.sum), t % MOD);
    check("ovf", int'(bus.ovf), int'(t >= MOD));
  endtask

  task automatic frame(input int a, input int b, input int c, input int d, input bit o);
    step(1, 0, 1, a, o);
    step(1, 0, 1, b, o);
    step(1, 0, 1, c, o);
    step(1, 0, 1, d, o);
  endtask

  initial begin
    step(0, 0, 1, 8'hFF, 0);
    step(0, 0, 1, 8'hFF, 0);
    step(1, 0, 0, 0, 1);
    frame(225, 9, 24, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    frame(1, 2, 3, 4, 0);
    repeat (5) step(1, 0, 1, 5, 0);
    step(1, 0, 1, 5, 1);
    step(1, 0, 0, 0, 0);
    frame(225, 225, 225, 225, 1);
    step(1, 0, 0, 0, 1);
    frame(1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 15, 0);
    step(1, 0, 1, 15, 0);
    step(1, 1, 1, 7, 0);
    frame(2, 2, 2, 2, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 30 + i, 0);
      step(1, 0, 0, 99, 0);
      step(1, 0, 0, 99, 0);
    end
    step(1, 0, 0, 0, 1);
    frame(100, 50, 25, 12, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 3, 0);
    frame(40, 41, 42, 43, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 32) == 0, $urandom_range(0, 9) < 7,
           int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    repeat (3) step(1, 0, 0, 0, 1);
    check("results_outstanding", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
